mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, operand width of each requester and of the shared multiplier.
REQ-002 The block SHALL provide parameter TIMEOUT, default 40, the maximum number of WAIT cycles allowed before an operation is aborted.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req0_valid/req1_valid  in  1  requester N presents an operand pair.
REQ-006 req0_ready/req1_ready  out  1  arbiter accepts requester N's operand pair this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  WIDTH  multiplicand and multiplier of requester N.
REQ-008 rsp0_valid/rsp1_valid  out  1  product for requester N is available.
REQ-009 rsp0_ready/rsp1_ready  in  1  requester N consumes the product.
REQ-010 rsp0_product/rsp1_product  out  2*WIDTH  signed product returned to requester N.
REQ-011 mul_start  out  1  one-cycle pulse launching the shared iterative multiplier.
REQ-012 mul_a, mul_b  out  WIDTH  operands driven to the shared multiplier.
REQ-013 mul_done  in  1  multiplier reports that mul_product is valid.
REQ-014 mul_product  in  2*WIDTH  multiplier result.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  sticky flag, set when an operation times out.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-018 In IDLE, the grant SHALL be: the only valid requester if one is valid; if both are valid, the requester not granted last (round-robin).
REQ-019 reqN_ready SHALL be high only in IDLE, only for the granted requester, and is combinational from reqN_valid and the round-robin pointer.
REQ-020 On handshake (valid & ready), the FSM SHALL latch the operands and grant id and go to ISSUE; reqN_ready SHALL be low in all other states.
REQ-021 ISSUE SHALL last exactly one cycle, assert mul_start for that cycle only, then go to WAIT.
REQ-022 mul_a/mul_b SHALL equal the latched operands from ISSUE through the end of WAIT, and are 0 in IDLE.
REQ-023 In WAIT, a cycle counter SHALL start at 0 and increment each cycle; on mul_done, mul_product SHALL be latched and the FSM goes to RESP.
REQ-024 If the counter reaches TIMEOUT-1 without mul_done, the latched product SHALL be 0, timeout_err SHALL set, and the FSM goes to RESP.
REQ-025 mul_done and mul_done coinciding with timeout: mul_done SHALL win, with no error.
REQ-026 mul_done asserted in IDLE, ISSUE or RESP SHALL be ignored.
REQ-027 In RESP, rspN_valid SHALL be high for the granted requester only; rspN_product SHALL hold the latched product until rspN_ready.
REQ-028 On rspN_valid & rspN_ready, the round-robin pointer SHALL update to N and the FSM returns to IDLE; a new request is accepted no earlier than the next cycle.
REQ-029 rspN_product for the non-granted requester SHALL read 0.
REQ-030 Latency: handshake at cycle T, mul_start at T+1; if mul_done arrives at T+1+k (k>=1), rspN_valid SHALL rise at T+2+k.
REQ-031 The product SHALL be passed through unmodified at 2*WIDTH bits; the arbiter performs no arithmetic on it.

Reset
REQ-032 While rst is high, the block SHALL be in IDLE with all outputs 0 and the counter 0.
REQ-033 Reset SHALL clear the latched operands, the latched product, timeout_err and busy, and set the round-robin pointer to 1 so that requester 0 wins first.
REQ-034 Reset mid-operation SHALL abort the operation with no response issued, and mul_start SHALL remain low.

Verification
REQ-035 Req0 only, a=7, b=-3, model done 16 cycles after start -> mul_start one pulse, rsp0_product=-21, rsp0_valid at handshake+18, req1 untouched.
REQ-036 Both valid from reset, continuously -> grants alternate 0,1,0,1; each product matches its own operands.
REQ-037 rsp0_ready held low 5 cycles in RESP -> rsp0_valid and product stable, no new acceptance, busy=1 throughout.
REQ-038 mul_done never asserts, TIMEOUT=40 -> RESP after 40 WAIT cycles, product 0, timeout_err=1 until reset.
REQ-039 rst pulsed in WAIT -> all outputs 0 next cycle, timeout_err 0, the following request from both goes to requester 0.
REQ-040 Operands 0x80000000 x 0x80000000 -> rsp product 0x4000000000000000 passed intact; spurious mul_done in IDLE -> no response.

Source files
------------

// File: rtl/mul_arbiter.sv
// Two-requester front end for one shared iterative multiplier.
// Round-robin grant in IDLE. The granted operands are held for the multiplier.
// The product (or 0 on timeout) is returned to whichever requester won the grant.
module mul_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [2*WIDTH-1:0]   rsp0_product,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [2*WIDTH-1:0]   rsp1_product,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             id;
  } op_t;

  state_t             state, state_nxt;
  op_t                op;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               rr_ptr;     // id of the requester granted last
  logic               gnt0, gnt1;
  logic               last_cyc;
  logic               rsp_hs;

  // Grant: a lone valid requester wins; on contention the one not served last wins
  assign gnt0     = req0_valid & (~req1_valid | rr_ptr);
  assign gnt1     = req1_valid & (~req0_valid | ~rr_ptr);
  assign last_cyc = (cnt == CW'(TIMEOUT - 1));
  assign rsp_hs   = (state == RESP) & (op.id ? rsp1_ready : rsp0_ready);
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and combinational outputs
  always_comb begin
    state_nxt    = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_product = '0;
    rsp1_product = '0;
    mul_start    = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    case (state)
      IDLE: begin
        // Gated by rst so every output reads 0 while reset is held
        req0_ready = gnt0 & ~rst;
        req1_ready = gnt1 & ~rst;
        if (gnt0 | gnt1) state_nxt = ISSUE;
      end
      ISSUE: begin
        mul_start = 1'b1;
        mul_a     = op.a;
        mul_b     = op.b;
        state_nxt = WAIT;
      end
      WAIT: begin
        mul_a = op.a;
        mul_b = op.b;
        if (mul_done || last_cyc) state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid   = ~op.id;
        rsp1_valid   = op.id;
        rsp0_product = op.id ? '0 : prod;
        rsp1_product = op.id ? prod : '0;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand and grant capture, wait counter, product and error latching, RR pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= '0;
      prod        <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt0 | gnt1) begin
            op.a  <= gnt1 ? req1_a : req0_a;
            op.b  <= gnt1 ? req1_b : req0_b;
            op.id <= gnt1;
          end
        end
        WAIT: begin
          // A done on the last allowed cycle still counts as a good result
          if (mul_done) begin
            prod <= mul_product;
            cnt  <= '0;
          end else if (last_cyc) begin
            prod        <= '0;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_hs) rr_ptr <= op.id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural shared-multiplier model.
module tb_mul_arbiter;
  localparam int W  = 32;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [2*W-1:0] rsp0_product, rsp1_product;
  logic          mul_start, mul_done;
  logic [W-1:0]  mul_a, mul_b;
  logic [2*W-1:0] mul_product;
  logic          busy, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_product(rsp0_product),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_product(rsp1_product),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier model: done pulses m_lat cycles after the start cycle
  logic           m_en, done_force, m_done;
  int             m_lat;
  int             m_cnt;
  logic [2*W-1:0] m_prod;
  assign mul_done    = m_done | done_force;
  assign mul_product = m_prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_start && m_en) begin
        m_cnt  <= m_lat - 1;
        m_prod <= $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_done <= 1'b1;
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one operand pair on requester id (assumed idle), then wait for its response
  task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int rsp_cyc, output int starts, output logic [2*W-1:0] prod,
                        output logic [W-1:0] sa, output logic [W-1:0] sb, output int other);
    @(posedge clk); #1;
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_cyc = -1; starts = 0; other = 0; prod = '0; sa = '0; sb = '0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (mul_start) begin starts++; sa = mul_a; sb = mul_b; end
      if (id == 0 ? rsp1_valid : rsp0_valid) other++;
      if (id == 0 ? rsp0_valid : rsp1_valid) begin
        rsp_cyc = c;
        prod    = (id == 0) ? rsp0_product : rsp1_product;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, timeout_err, mul_start, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0", {busy, timeout_err, mul_start, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    n_cmp++;
    if ({mul_a, mul_b, rsp0_product, rsp1_product} !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {mul_a, mul_b, rsp0_product, rsp1_product});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int cyc, st, oth;
    logic [2*W-1:0] p;
    logic [W-1:0] sa, sb;
    m_lat = 16;
    do_req(0, 32'd7, 32'hFFFF_FFFD, cyc, st, p, sa, sb, oth);
    n_cmp++; if (cyc !== 18) begin n_err++; $display("FAIL single_latency: got %0d want 18", cyc); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL single_starts: got %0d want 1", st); end
    n_cmp++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL single_prod: got %h want ffffffffffffffeb", p); end
    n_cmp++; if ({sa, sb} !== {32'd7, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL single_ops: got %h %h want 7 fffffffd", sa, sb); end
    n_cmp++; if (oth !== 0) begin n_err++; $display("FAIL single_rsp1: got %0d want 0", oth); end
    @(negedge clk);
    n_cmp++; if ({busy, mul_a, mul_b} !== '0) begin n_err++; $display("FAIL single_idle: got %h want 0", {busy, mul_a, mul_b}); end
  endtask

  task automatic test_round_robin();
    int g[4];
    int ng = 0;
    int nr = 0;
    pulse_reset();
    m_lat = 3;
    req0_a = 32'd5; req0_b = 32'd6;
    req1_a = 32'hFFFF_FFFC; req1_b = 32'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 150 && !(ng == 4 && nr == 4); c++) begin
      @(negedge clk);
      if (req0_ready && ng < 4) begin g[ng] = 0; ng++; end
      if (req1_ready && ng < 4) begin g[ng] = 1; ng++; end
      if (rsp0_valid) begin
        nr++; n_cmp++;
        if (rsp0_product !== 64'd30) begin n_err++; $display("FAIL rr_prod0: got %h want 1e", rsp0_product); end
      end
      if (rsp1_valid) begin
        nr++; n_cmp++;
        if (rsp1_product !== 64'hFFFF_FFFF_FFFF_FFDC) begin n_err++; $display("FAIL rr_prod1: got %h want ffffffffffffffdc", rsp1_product); end
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++; if (nr !== 4 || ng !== 4) begin n_err++; $display("FAIL rr_count: got %0d grants %0d rsps want 4 4", ng, nr); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++;
      if (g[i] !== (i % 2)) begin n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", i, g[i], i % 2); end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int cyc, st, oth;
    logic [2*W-1:0] p;
    logic [W-1:0] sa, sb;
    m_lat = 4;
    rsp0_ready = 1'b0;
    do_req(0, 32'd11, 32'd12, cyc, st, p, sa, sb, oth);
    n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL bp_latency: got %0d want 6", cyc); end
    n_cmp++; if (p !== 64'd132) begin n_err++; $display("FAIL bp_prod: got %h want 84", p); end
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp0_valid, busy, req1_ready} !== 3'b110 || rsp0_product !== 64'd132) begin
        n_err++; $display("FAIL bp_hold%0d: got v/b/r %b prod %h want 110 84", i, {rsp0_valid, busy, req1_ready}, rsp0_product);
      end
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({busy, rsp0_valid} !== 2'b00) begin n_err++; $display("FAIL bp_release: got %b want 00", {busy, rsp0_valid}); end
  endtask

  task automatic test_timeout();
    int cyc, st, oth;
    logic [2*W-1:0] p;
    logic [W-1:0] sa, sb;
    m_en = 1'b0;
    do_req(1, 32'd3, 32'd4, cyc, st, p, sa, sb, oth);
    n_cmp++; if (cyc !== TO + 2) begin n_err++; $display("FAIL to_latency: got %0d want %0d", cyc, TO + 2); end
    n_cmp++; if (p !== 64'd0) begin n_err++; $display("FAIL to_prod: got %h want 0", p); end
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", timeout_err); end
    m_en = 1'b1; m_lat = 5;
    do_req(0, 32'd2, 32'd3, cyc, st, p, sa, sb, oth);
    n_cmp++; if (p !== 64'd6) begin n_err++; $display("FAIL to_next_prod: got %h want 6", p); end
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    int got = 0;
    m_lat = 16;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_inwait: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, timeout_err, mul_start, rsp0_valid, rsp1_valid, mul_a, mul_b, rsp0_product, rsp1_product} !== '0) begin
      n_err++; $display("FAIL rm_outputs: got busy %b err %b mul_a %h", busy, timeout_err, mul_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_start || rsp0_valid || rsp1_valid || busy || timeout_err) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rm_quiet: got %0d active cycles want 0", bad); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd9;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3;
    @(negedge clk);
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rm_grant: got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp0_valid) begin got = 1; break; end
    end
    n_cmp++;
    if (got !== 1 || rsp0_product !== 64'd18) begin n_err++; $display("FAIL rm_rsp: got seen %0d prod %h want 1 12", got, rsp0_product); end
    @(posedge clk); #1;
  endtask

  task automatic test_corner();
    int cyc, st, oth;
    int bad = 0;
    logic [2*W-1:0] p;
    logic [W-1:0] sa, sb;
    m_lat = 2;
    do_req(0, 32'h8000_0000, 32'h8000_0000, cyc, st, p, sa, sb, oth);
    n_cmp++; if (p !== 64'h4000_0000_0000_0000) begin n_err++; $display("FAIL corner_prod: got %h want 4000000000000000", p); end
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL corner_latency: got %0d want 4", cyc); end
    @(posedge clk); #1;
    done_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) bad++;
    end
    @(posedge clk); #1;
    done_force = 1'b0;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL spurious_done: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    m_en = 1'b1; m_lat = 4; done_force = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
